// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with HI/LO result registers.
//
// Operations (op): 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. An accepted start runs for
// exactly WIDTH clock edges (one product or quotient bit per edge), then HI/LO are
// written and done pulses for one cycle. Signed operations work on magnitudes and
// fix the signs up when the result is written.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high reset
//   start        begin an operation (ignored while busy)
//   op           operation select
//   a, b         operands (multiplicand/dividend, multiplier/divisor)
//   hi_we, lo_we direct writes of HI/LO from wdata when not busy
//   wdata        data for hi_we / lo_we
//   hi, lo       result registers
//   busy         operation in progress
//   done         one-cycle pulse, HI/LO hold a new result
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic               is_div_q, neg_lo_q, neg_hi_q;
    // acc_q: product high half / partial remainder.
    // mq_q:  multiplier (shifted out) + product low half / dividend -> quotient.
    // opnd_q: multiplicand magnitude / divisor magnitude.
    logic [WIDTH-1:0]   acc_q, mq_q, opnd_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               accept, last;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum, sh;
    logic [WIDTH-1:0]   rem_sub;
    logic [WIDTH-1:0]   acc_d, mq_d;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign accept = start && (state_q != StRun);
    assign last   = (state_q == StRun) && (cnt_q == CW'(WIDTH - 1));

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Operand magnitudes; op[0] selects signed interpretation.
    assign sign_a = op[0] & a[WIDTH-1];
    assign sign_b = op[0] & b[WIDTH-1];
    assign mag_a  = sign_a ? -a : a;
    assign mag_b  = sign_b ? -b : b;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: state_d = start ? StRun : StIdle;
            StRun:          if (last) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    // One iteration step: shift-add multiply or restoring division.
    always_comb begin
        addend  = mq_q[0] ? opnd_q : '0;
        sum     = {1'b0, acc_q} + {1'b0, addend};
        sh      = {acc_q, mq_q[WIDTH-1]};
        rem_sub = sh[WIDTH-1:0] - opnd_q;
        if (is_div_q) begin
            // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend.
            if (sh >= {1'b0, opnd_q}) begin
                acc_d = rem_sub;
                mq_d  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = sh[WIDTH-1:0];
                mq_d  = {mq_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = sum[WIDTH:1];
            mq_d  = {sum[0], mq_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up applied on the final step.
    always_comb begin
        prod   = {acc_d, mq_d};
        prod_s = neg_lo_q ? -prod : prod;
        if (is_div_q) begin
            res_lo = neg_lo_q ? -mq_d : mq_d;
            res_hi = neg_hi_q ? -acc_d : acc_d;
        end else begin
            res_lo = prod_s[WIDTH-1:0];
            res_hi = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            acc_q    <= '0;
            mq_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                cnt_q    <= '0;
                is_div_q <= op[1];
                acc_q    <= '0;
                mq_q     <= op[1] ? mag_a : mag_b;
                opnd_q   <= op[1] ? mag_b : mag_a;
                // Divide by zero keeps the all-ones quotient unsigned; remainder keeps sign of a.
                neg_lo_q <= (sign_a ^ sign_b) && !(op[1] && (b == '0));
                neg_hi_q <= op[1] ? sign_a : (sign_a ^ sign_b);
            end else if (state_q == StRun) begin
                cnt_q <= cnt_q + 1'b1;
                acc_q <= acc_d;
                mq_q  <= mq_d;
            end

            if (state_q != StRun) begin
                if (hi_we) hi_q <= wdata;
                if (lo_we) lo_q <= wdata;
            end else if (last) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset, start, hi_we, lo_we;
    logic [1:0]    op;
    logic [W-1:0]  a, b, wdata;
    logic [W-1:0]  hi, lo;
    logic          busy, done;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  exp_hi, exp_lo;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference model: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint sx, sy, q, rm;
        logic [63:0] r;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            2'd0: r = {32'b0, x} * {32'b0, y};
            2'd1: r = sx * sy;
            2'd2: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    q  = sx / sy;
                    rm = sx % sy;
                    r  = {rm[31:0], q[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv)
        else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, expv);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with the op running.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic with_we);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        hi_we = with_we;
        lo_we = with_we;
        wdata = $urandom;
        {exp_hi, exp_lo} = ref_model(o, x, y);
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom);
        check("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    // Counts busy cycles (bounded), optionally with noise on inputs, then checks the result.
    task automatic wait_result(input string tag, input logic noisy);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (noisy) begin
                start = 1'($urandom);
                op    = 2'($urandom);
                a     = $urandom;
                b     = $urandom;
                hi_we = 1'($urandom);
                lo_we = 1'($urandom);
                wdata = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check({tag, "_busy_cycles"}, n, W);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
        check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_hold_hi"}, hi, exp_hi);
        check({tag, "_hold_lo"}, lo, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n_done, n_busy;
        logic [1:0]  ro;
        logic [31:0] rx, ry;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        #2;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed operations
        @(negedge clk);
        launch(2'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
        wait_result("mult_neg", 1'b0);
        check("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo_const", lo, 32'hFFFF_FFEB);
        idle_check("mult_neg");

        @(negedge clk);
        launch(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_result("multu_max", 1'b0);
        check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
        check("multu_max_lo_const", lo, 32'h0000_0001);
        idle_check("multu_max");

        @(negedge clk);
        launch(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_result("div_neg", 1'b0);
        check("div_neg_hi_const", hi, 32'hFFFF_FFFF);
        check("div_neg_lo_const", lo, 32'hFFFF_FFFD);
        idle_check("div_neg");

        @(negedge clk);
        launch(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_result("div_ovf", 1'b0);
        check("div_ovf_hi_const", hi, 32'h0);
        check("div_ovf_lo_const", lo, 32'h8000_0000);
        idle_check("div_ovf");

        @(negedge clk);
        launch(2'd2, 32'h0000_1234, 32'h0, 1'b0);
        wait_result("divu_zero", 1'b0);
        check("divu_zero_hi_const", hi, 32'h0000_1234);
        check("divu_zero_lo_const", lo, 32'hFFFF_FFFF);
        idle_check("divu_zero");

        @(negedge clk);
        launch(2'd3, 32'hFFFF_FF00, 32'h0, 1'b0);
        wait_result("div_zero_neg", 1'b1);
        idle_check("div_zero_neg");

        // Direct HI/LO writes while idle
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0;
        exp_hi = 32'hDEAD_BEEF;
        check("mthi_hi", hi, exp_hi);
        check("mthi_lo_held", lo, exp_lo);
        lo_we = 1'b1;
        wdata = 32'h0BAD_F00D;
        @(negedge clk);
        lo_we = 1'b0;
        exp_lo = 32'h0BAD_F00D;
        check("mtlo_lo", lo, exp_lo);
        check("mtlo_hi_held", hi, exp_hi);

        // Write in the same cycle as start; the result overwrites both registers
        launch(2'd0, $urandom, $urandom, 1'b1);
        wait_result("start_with_we", 1'b1);

        // Back-to-back: second start during DONE
        idle_check("start_with_we");
        launch(2'd3, $urandom, $urandom, 1'b0);
        wait_result("b2b_first", 1'b1);
        launch(2'd2, 32'd100, 32'd7, 1'b0);
        wait_result("b2b_second", 1'b1);
        check("b2b_lo_const", lo, 32'd14);
        check("b2b_hi_const", hi, 32'd2);
        idle_check("b2b_second");

        // Randomized operations, some chained back-to-back
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom);
            rx = pick();
            ry = pick();
            launch(ro, rx, ry, 1'b0);
            wait_result("rand", 1'(i));
            if ($urandom_range(0, 1) == 0) idle_check("rand");
        end
        idle_check("rand_end");

        // Reset in the middle of RUN
        launch(2'd0, $urandom | 32'h1, $urandom | 32'h1, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrun_reset_hi", hi, 32'h0);
        check("midrun_reset_lo", lo, 32'h0);
        check("midrun_reset_busy", {31'b0, busy}, 32'd0);
        check("midrun_reset_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        n_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (busy === 1'b1) n_busy++;
        end
        check("post_reset_no_done", n_done, 32'd0);
        check("post_reset_no_busy", n_busy, 32'd0);
        check("post_reset_lo", lo, 32'h0);
        hi_we = 1'b1;
        wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        check("post_reset_mthi", hi, 32'hA5A5_A5A5);
        check("post_reset_lo_held", lo, 32'h0);

        launch(2'd2, $urandom, $urandom_range(1, 1000), 1'b0);
        wait_result("post_reset_op", 1'b0);
        idle_check("post_reset_op");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand width and width of each of HI and LO; legal values 8..64, even.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an operation.
REQ-005 Port: op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 Port: a  input  WIDTH  first operand (multiplicand / dividend).
REQ-007 Port: b  input  WIDTH  second operand (multiplier / divisor).
REQ-008 Port: hi_we  input  1  direct write of HI (MTHI).
REQ-009 Port: lo_we  input  1  direct write of LO (MTLO).
REQ-010 Port: wdata  input  WIDTH  data for hi_we / lo_we.
REQ-011 Port: hi  output  WIDTH  HI register (MFHI source).
REQ-012 Port: lo  output  WIDTH  LO register (MFLO source).
REQ-013 Port: busy  output  1  operation in progress; start ignored.
REQ-014 Port: done  output  1  one-cycle pulse, HI/LO hold a new result.

Function
REQ-015 The unit SHALL be an iterative FSM with states IDLE, RUN, DONE, plus a cycle counter of clog2(WIDTH) bits.
REQ-016 In IDLE or DONE, start=1 at a rising edge SHALL latch op, a and b, clear the counter and enter RUN.
REQ-017 RUN SHALL last exactly WIDTH edges (one quotient or product bit per edge); the edge with counter = WIDTH-1 SHALL write HI/LO and enter DONE.
REQ-018 Latency: start sampled at edge k -> HI/LO updated and done=1 after edge k+WIDTH.
REQ-019 DONE SHALL last one cycle and then return to IDLE, or to RUN if start=1 (back-to-back, no idle gap).
REQ-020 busy SHALL be 1 exactly while state is RUN; done SHALL be 1 exactly while state is DONE.
REQ-021 start while busy=1 SHALL be ignored; operand changes during RUN SHALL NOT affect the result.
REQ-022 MULTU: {HI,LO} = unsigned 2*WIDTH-bit product of a and b.
REQ-023 MULT: {HI,LO} = two's-complement 2*WIDTH-bit product; magnitudes multiplied, result negated when sign(a) xor sign(b).
REQ-024 DIVU: LO = a / b, HI = a mod b, unsigned, restoring or non-restoring algorithm.
REQ-025 DIV: magnitude division; LO negated when sign(a) xor sign(b); HI takes the sign of a (truncation toward zero).
REQ-026 DIV with a = most-negative value and b = -1 SHALL give LO = most-negative value, HI = 0.
REQ-027 Divide by zero (DIVU or DIV): LO = all ones, HI = a; timing SHALL be identical to any other division.
REQ-028 hi_we / lo_we SHALL update HI / LO from wdata at the next edge when busy=0; when busy=1 they SHALL be ignored.
REQ-029 hi_we/lo_we in the same cycle as an accepted start SHALL take effect; the later result SHALL overwrite both registers.
REQ-030 HI and LO SHALL hold their value at all times other than REQ-017 and REQ-028 writes.

Reset
REQ-031 reset=1 SHALL immediately and asynchronously force state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, regardless of clock.
REQ-032 Reset asserted mid-RUN SHALL abort the operation; no result SHALL be written and no done pulse SHALL follow reset release.
REQ-033 After reset deassertion, the first edge with start=1 SHALL be accepted normally.

Verification (WIDTH=32)
REQ-034 MULT a=0xFFFFFFFD (-3), b=7 -> 32 edges later done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 32 cycles.
REQ-035 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-037 DIVU a=0x1234, b=0 -> after 32 edges lo=0xFFFFFFFF, hi=0x00001234.
REQ-038 Back-to-back: second start (DIVU 100/7) raised during DONE of first -> busy re-asserts next cycle; result lo=14, hi=2; start pulses during RUN and hi_we during RUN ignored.
REQ-039 Reset asserted at RUN cycle 10, released mid-cycle -> hi=lo=0, busy=0, no done pulse; then hi_we wdata=0xA5A5A5A5 -> hi=0xA5A5A5A5 next edge.
